sobel_window_reader: RTL and testbench
======================================

# sobel_window_reader

Consumer side of the pixel line-buffer path: takes the raster pixel stream written into the line buffers and emits one 3x3 neighbourhood per accepted pixel once two full lines plus two pixels have been seen. It owns two internal line delays and a 3x3 register window. It sits between the pixel source and the Sobel gradient arithmetic. Output is a flat 72-bit window with a qualifying valid strobe and an end-of-frame pulse.

## Interface
- WIDTH, 640: pixels per line; legal range 3 or more.
- HEIGHT, 480: lines per frame; legal range 3 or more.
- DATA_W, 8: bits per pixel.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- we_i  in  1  pixel strobe; data_i is accepted on every rising edge where we_i=1.
- data_i  in  DATA_W  pixel value in raster order.
- win_o  out  9*DATA_W  3x3 window.
  - Slot k = 3*row + col occupies bits [DATA_W*k +: DATA_W].
  - row 0 is the oldest line; col 0 is the leftmost column.
- valid_o  out  1  win_o holds a complete in-frame window.
- done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Counters:
  - col: 0..WIDTH-1.
  - row: 0..HEIGHT-1.
  - Width of each counter is $clog2 of its limit.
  - Both counters advance only on accepted pixels.
- Line delays:
  - lb1 and lb2 are WIDTH-entry memories addressed by col.
  - Each is read-before-write in the same cycle.
  - On accept at (r,c):
    - lb1[c] provides p(r-1,c); lb2[c] provides p(r-2,c).
    - p(r,c) is written to lb1[c].
    - The old lb1[c] is written to lb2[c].
- Window shift on accept:
  - Each window row shifts left by one column.
  - The new column 2 is {p(r-2,c), p(r-1,c), p(r,c)}, loaded into rows 0, 1 and 2.
- Valid qualification:
  - valid_o is registered; it is 1 after an accept with r>=2 and c>=2, otherwise 0.
  - The resulting window is centred at (r-1,c-1).
  - Windows never straddle lines: column 2 is the first valid column on every line.
- Wrap:
  - col = WIDTH-1 goes to 0 and row increments.
  - At (HEIGHT-1, WIDTH-1): row and col both go to 0, and done_o = 1 for one cycle.
- Idle: when we_i=0, counters, window and memories hold; valid_o=0 and done_o=0.
- Line-delay contents are never reset. Stale data from before reset or from a previous frame is masked by the row>=2 gate.
- Reset values: valid_o=0, done_o=0, win_o=0, col=0, row=0.
- Reset mid-frame: the next accepted pixel is treated as (0,0), and no valid_o is raised until (2,2) of the new frame.

## Timing
- Latency: one cycle from the accepting edge to win_o/valid_o/done_o.
- Throughput: one window per clock while we_i is held high.
- valid_o and done_o are coincident on the last pixel of a frame.
- Back-to-back frames need no gap cycles.
- Per frame: exactly (HEIGHT-2)*(WIDTH-2) valid_o cycles and exactly one done_o.

## Structure
- Shared package holds:
  - the DATA_W default;
  - a win_idx(row,col) function returning 3*row+col;
  - the counter-width helper.
- One sub-module: sobel_line_delay. Parameters WIDTH and DATA_W; ports clk, we, addr, din, dout. It is a read-before-write RAM, instantiated twice.
- Top level: counters, window registers, valid/done registers.

## Test plan
All scenarios use WIDTH=5 and HEIGHT=4.
- Reset: rst=0 for 2 cycles, then release -> win_o=0, valid_o=0, done_o=0.
- Fill: stream 1..20 with we_i=1 continuously.
  - valid_o first rises the cycle after pixel 13, with slots 0..8 = 1,2,3,6,7,8,11,12,13.
  - valid_o is high for 6 cycles in total, in runs of 3 after pixels 13..15 and 18..20.
  - The window after pixel 20 = 8,9,10,13,14,15,18,19,20.
- Frame wrap: pixel 20 -> done_o=1 for exactly one cycle. Stream 21..40 immediately -> valid_o first rises after pixel 33 with slots 21,22,23,26,27,28,31,32,33.
- Gaps: same 1..20 with we_i=0 for 3 cycles after every other pixel -> identical window sequence. valid_o and done_o are never high during idle cycles.
- Reset mid-frame: assert rst after pixel 12, then restart at 1..20 -> no valid_o before new pixel 13, and the first window is 1,2,3,6,7,8,11,12,13.
- Line boundary: check that no valid_o occurs after pixels 16 or 17 (cols 0 and 1 of row 3).

Source files
------------

// File: rtl/sobel_window_reader_pkg.sv
// Shared constants and helpers for the Sobel window reader and its line delays.
package sobel_window_reader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WIN_SLOTS  = 9;

  // Counter/address width for a 0..limit-1 range; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  function automatic logic [3:0] win_idx(input int row, input int col);
    return 4'(3 * row + col);
  endfunction

endpackage

// File: rtl/sobel_window_reader_line_delay.sv
// One line of pixel delay: WIDTH-entry RAM, combinational read of the old word
// while the new word is written on the same edge (read-before-write).
module sobel_line_delay
  import sobel_window_reader_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [cnt_w(WIDTH)-1:0]    addr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout
);

  // Contents are deliberately unreset; the reader masks stale lines by row count.
  logic [DATA_W-1:0] mem_q [WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/sobel_window_reader.sv
// Raster pixel stream in, one 3x3 neighbourhood out per accepted pixel once
// two lines plus two pixels of the current frame have been seen.
module sobel_window_reader
  import sobel_window_reader_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [9*DATA_W-1:0]   win_o,
  output logic                  valid_o,
  output logic                  done_o
);

  localparam int CW = cnt_w(WIDTH);
  localparam int RW = cnt_w(HEIGHT);

  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] win_q [WIN_SLOTS];
  logic [DATA_W-1:0] win_d [WIN_SLOTS];
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] lb1_dout;
  logic [DATA_W-1:0] lb2_dout;
  logic              col_last;
  logic              row_last;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // lb1 holds the previous line; its old word cascades into lb2 on the same write.
  sobel_line_delay #(
    .WIDTH  (WIDTH),
    .DATA_W (DATA_W)
  ) u_lb1 (
    .clk  (clk),
    .we   (we_i),
    .addr (col_q),
    .din  (data_i),
    .dout (lb1_dout)
  );

  sobel_line_delay #(
    .WIDTH  (WIDTH),
    .DATA_W (DATA_W)
  ) u_lb2 (
    .clk  (clk),
    .we   (we_i),
    .addr (col_q),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (we_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (we_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
        win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
      end
      win_d[win_idx(0, 2)] = lb2_dout;
      win_d[win_idx(1, 2)] = lb1_dout;
      win_d[win_idx(2, 2)] = data_i;
    end
  end

  // Column gate restarts every line so windows never wrap across a line edge.
  always_comb begin
    valid_d = we_i && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    done_d  = we_i && col_last && row_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '{default: '0};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    win_o = '0;
    for (int k = 0; k < WIN_SLOTS; k++) begin
      win_o[DATA_W*k +: DATA_W] = win_q[k];
    end
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_sobel_window_reader.sv
// Scoreboard bench for sobel_window_reader on a 5x4 frame: driver queues
// hand-computed windows, a negedge monitor pops and compares them.
module tb_sobel_window_reader;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic            we_i;
  logic [DW-1:0]   data_i;
  logic [9*DW-1:0] win_o;
  logic            valid_o;
  logic            done_o;

  sobel_window_reader #(
    .WIDTH  (W),
    .HEIGHT (H),
    .DATA_W (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_i),
    .data_i  (data_i),
    .win_o   (win_o),
    .valid_o (valid_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_seen = 0;
  int done_seen  = 0;

  // Hand-computed windows (slots 0..8) for pixel numbers 1..20 of a frame.
  int exp_pix [6] = '{13, 14, 15, 18, 19, 20};
  int exp_win [6][9] = '{
    '{1, 2, 3,  6,  7,  8, 11, 12, 13},
    '{2, 3, 4,  7,  8,  9, 12, 13, 14},
    '{3, 4, 5,  8,  9, 10, 13, 14, 15},
    '{6, 7, 8, 11, 12, 13, 16, 17, 18},
    '{7, 8, 9, 12, 13, 14, 17, 18, 19},
    '{8, 9, 10, 13, 14, 15, 18, 19, 20}
  };

  logic [9*DW-1:0] sb_q [$];

  logic exp_valid_drv = 1'b0;
  logic exp_done_drv  = 1'b0;
  int   n_drv         = 0;
  logic exp_valid_e   = 1'b0;
  logic exp_done_e    = 1'b0;
  int   n_e           = 0;
  logic we_e          = 1'b0;

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check72(input string name, input logic [9*DW-1:0] got, input logic [9*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] pack_win(input int i, input int off);
    logic [9*DW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[DW*k +: DW] = DW'(exp_win[i][k] + off);
    end
    return w;
  endfunction

  // Expected strobes pipelined by one edge so they line up with the registered outputs.
  always @(posedge clk) begin
    exp_valid_e <= exp_valid_drv;
    exp_done_e  <= exp_done_drv;
    n_e         <= n_drv;
    we_e        <= we_i;
  end

  always @(negedge clk) begin
    if (rst) begin
      check1("valid_timing", valid_o, exp_valid_e);
      check1("done_timing", done_o, exp_done_e);
      if (valid_o) valid_seen++;
      if (done_o) done_seen++;
      if (we_e && (n_e == 16 || n_e == 17)) begin
        check1("line_boundary", valid_o, 1'b0);
      end
      if (valid_o) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_window: got %h expected none at %0t", win_o, $time);
        end else begin
          check72("window", win_o, sb_q.pop_front());
        end
      end
    end
  end

  task automatic send(input int px, input int n, input int off);
    @(negedge clk);
    we_i          = 1'b1;
    data_i        = DW'(px);
    n_drv         = n;
    exp_done_drv  = (n == 20);
    exp_valid_drv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (exp_pix[i] == n) begin
        exp_valid_drv = 1'b1;
        sb_q.push_back(pack_win(i, off));
      end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      we_i          = 1'b0;
      n_drv         = 0;
      exp_valid_drv = 1'b0;
      exp_done_drv  = 1'b0;
    end
  endtask

  task automatic scenario_end(input string name, input int v0, input int d0,
                              input int v_exp, input int d_exp);
    check_int({name, "_valid_count"}, valid_seen - v0, v_exp);
    check_int({name, "_done_count"}, done_seen - d0, d_exp);
    check_int({name, "_sb_left"}, sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int d0;
    rst    = 1'b0;
    we_i   = 1'b0;
    data_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check72("reset_win", win_o, '0);
    check1("reset_valid", valid_o, 1'b0);
    check1("reset_done", done_o, 1'b0);

    // Two back-to-back frames, no gap at the wrap.
    v0 = valid_seen; d0 = done_seen;
    for (int n = 1; n <= 20; n++) send(n, n, 0);
    for (int n = 1; n <= 20; n++) send(n + 20, n, 20);
    idle(3);
    scenario_end("fill_wrap", v0, d0, 12, 2);

    // Three idle cycles after every other pixel.
    v0 = valid_seen; d0 = done_seen;
    for (int n = 1; n <= 20; n++) begin
      send(n, n, 0);
      if (n % 2 == 0) idle(3);
    end
    idle(3);
    scenario_end("gaps", v0, d0, 6, 1);

    // Reset in the middle of row 2, then a fresh frame.
    v0 = valid_seen; d0 = done_seen;
    for (int n = 1; n <= 12; n++) send(n, n, 0);
    @(negedge clk);
    we_i          = 1'b0;
    n_drv         = 0;
    exp_valid_drv = 1'b0;
    exp_done_drv  = 1'b0;
    rst           = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check72("midreset_win", win_o, '0);
    check1("midreset_valid", valid_o, 1'b0);
    for (int n = 1; n <= 20; n++) send(n, n, 0);
    idle(3);
    scenario_end("midreset", v0, d0, 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
